// File: rtl/aes_masked_input_loader.sv
// Masks eight 32-bit words (4 plaintext, 4 key) into d Boolean shares and hands the shared block to the AES core.
// core_valid rises the cycle after word 7 is accepted. in_ready is low while the block is held for the core.
module aes_masked_input_loader #(
  parameter int d = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic [32*(d-1)-1:0]  rnd_in,
  output logic [128*d-1:0]     sh_plaintext,
  output logic [128*d-1:0]     sh_key,
  output logic                 core_valid,
  input  logic                 core_ready,
  output logic                 busy
);

  typedef enum logic {FILL, FULL} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [128*d-1:0]   pt_q, key_q;
  logic [32*d-1:0]    word_sh;
  logic               accept, xfer;

  // Bit b of the word lands at b*d+j, so a whole word is one contiguous 32*d slice.
  always_comb begin
    word_sh = '0;
    for (int b = 0; b < 32; b++) begin
      word_sh[b*d] = in_data[b];
      for (int j = 1; j < d; j++) begin
        word_sh[b*d+j] = rnd_in[(j-1)*32+b];
        word_sh[b*d]   = word_sh[b*d] ^ rnd_in[(j-1)*32+b];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    core_valid = 1'b0;
    accept     = 1'b0;
    xfer       = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = FULL;
        end
      end
      FULL: begin
        core_valid = 1'b1;
        xfer       = core_ready;
        if (core_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    // Abort wins over any word or transfer in the same cycle.
    if (clear) begin
      state_d = FILL;
      cnt_d   = '0;
      accept  = 1'b0;
      xfer    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      pt_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (clear || xfer) begin
        pt_q  <= '0;
        key_q <= '0;
      end else if (accept) begin
        for (int w = 0; w < 4; w++) begin
          if (cnt_q == 3'(w))   pt_q[w*32*d +: 32*d]  <= word_sh;
          if (cnt_q == 3'(w+4)) key_q[w*32*d +: 32*d] <= word_sh;
        end
      end
    end
  end

  // Partially filled registers are never visible to the core.
  assign sh_plaintext = (state_q == FULL) ? pt_q  : '0;
  assign sh_key       = (state_q == FULL) ? key_q : '0;
  assign busy         = (cnt_q != 3'd0) || (state_q == FULL);

endmodule

// File: tb/tb_aes_masked_input_loader.sv
// Bench for aes_masked_input_loader: d=2 and d=3 instances share stimulus and are
// compared each cycle against a word-level model of the sharing rules.
module tb_aes_masked_input_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, clear, in_valid, core_ready;
  logic [31:0] in_data;
  logic [63:0] rnd3;

  logic         in_ready2, core_valid2, busy2;
  logic [255:0] sh_pt2, sh_key2;
  logic         in_ready3, core_valid3, busy3;
  logic [383:0] sh_pt3, sh_key3;

  aes_masked_input_loader #(.d(2)) dut2 (
    .clk(clk), .nrst(nrst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .rnd_in(rnd3[31:0]), .sh_plaintext(sh_pt2), .sh_key(sh_key2),
    .core_valid(core_valid2), .core_ready(core_ready), .busy(busy2)
  );

  aes_masked_input_loader #(.d(3)) dut3 (
    .clk(clk), .nrst(nrst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .rnd_in(rnd3), .sh_plaintext(sh_pt3), .sh_key(sh_key3),
    .core_valid(core_valid3), .core_ready(core_ready), .busy(busy3)
  );

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

  int checks = 0;
  int errors = 0;

  // Model: words and masks accepted so far in the current block.
  int          m_cnt;
  bit          m_full;
  logic [31:0] mw[8];
  logic [63:0] mr[8];

  typedef struct {
    logic [31:0] data;
    logic        exp_busy;
    logic        exp_cv;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [383:0] exp_sh(input int dd, input bit key);
    logic [383:0] v;
    logic [31:0]  wd;
    logic [63:0]  r;
    int           base;
    v = '0;
    for (int w = 0; w < 4; w++) begin
      wd = key ? mw[w+4] : mw[w];
      r  = key ? mr[w+4] : mr[w];
      for (int b = 0; b < 32; b++) begin
        base = (32*w + b) * dd;
        if (dd == 2) begin
          v[base]   = wd[b] ^ r[b];
          v[base+1] = r[b];
        end else begin
          v[base]   = wd[b] ^ r[b] ^ r[32+b];
          v[base+1] = r[b];
          v[base+2] = r[32+b];
        end
      end
    end
    return v;
  endfunction

  function automatic logic [127:0] recomb(input logic [383:0] v, input int dd);
    logic [127:0] x;
    x = '0;
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < dd; j++) x[i] = x[i] ^ v[i*dd+j];
    return x;
  endfunction

  function automatic logic [127:0] share(input logic [383:0] v, input int dd, input int j);
    logic [127:0] x;
    x = '0;
    for (int i = 0; i < 128; i++) x[i] = v[i*dd+j];
    return x;
  endfunction

  task automatic check_outputs();
    chk("in_ready2",   384'(in_ready2),   384'(!m_full));
    chk("core_valid2", 384'(core_valid2), 384'(m_full));
    chk("busy2",       384'(busy2),       384'(m_full || m_cnt != 0));
    chk("sh_pt2",  {128'b0, sh_pt2},  m_full ? exp_sh(2, 1'b0) : 384'b0);
    chk("sh_key2", {128'b0, sh_key2}, m_full ? exp_sh(2, 1'b1) : 384'b0);
    chk("in_ready3",   384'(in_ready3),   384'(!m_full));
    chk("core_valid3", 384'(core_valid3), 384'(m_full));
    chk("busy3",       384'(busy3),       384'(m_full || m_cnt != 0));
    chk("sh_pt3",  sh_pt3,  m_full ? exp_sh(3, 1'b0) : 384'b0);
    chk("sh_key3", sh_key3, m_full ? exp_sh(3, 1'b1) : 384'b0);
  endtask

  // One clock edge: sample the driven inputs, advance the model, check #1 later.
  task automatic step();
    logic        c, v, r;
    logic [31:0] dat;
    logic [63:0] rn;
    c = clear; v = in_valid; r = core_ready; dat = in_data; rn = rnd3;
    @(posedge clk);
    if (c) begin
      m_cnt  = 0;
      m_full = 0;
    end else if (m_full) begin
      if (r) m_full = 0;
    end else if (v) begin
      mw[m_cnt] = dat;
      mr[m_cnt] = rn;
      if (m_cnt == 7) begin
        m_cnt  = 0;
        m_full = 1;
      end else begin
        m_cnt++;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic load_word(input logic [31:0] dat, input logic [63:0] rn);
    in_valid = 1'b1;
    in_data  = dat;
    rnd3     = rn;
    step();
    in_valid = 1'b0;
  endtask

  task automatic load_table(input bit random_rnd);
    for (int i = 0; i < 8; i++) begin
      load_word(tbl[i].data, random_rnd ? {$urandom, $urandom} : 64'b0);
      chk("tbl_busy", 384'(busy2), 384'(tbl[i].exp_busy));
      chk("tbl_cv",   384'(core_valid2), 384'(tbl[i].exp_cv));
    end
  endtask

  task automatic check_recomb(input string tag);
    chk({tag, "_pt2"},  384'(recomb({128'b0, sh_pt2}, 2)),  384'(PT));
    chk({tag, "_key2"}, 384'(recomb({128'b0, sh_key2}, 2)), 384'(KEY));
    chk({tag, "_pt3"},  384'(recomb(sh_pt3, 3)),  384'(PT));
    chk({tag, "_key3"}, 384'(recomb(sh_key3, 3)), 384'(KEY));
  endtask

  initial begin
    logic [31:0] words[8];
    int          pulses, first_pulse, second_pulse;
    words = '{32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233,
              32'h0c0d0e0f, 32'h08090a0b, 32'h04050607, 32'h00010203};
    for (int i = 0; i < 8; i++) tbl[i] = '{words[i], 1'b1, (i == 7)};

    nrst = 1'b0; clear = 1'b0; in_valid = 1'b0; core_ready = 1'b0;
    in_data = '0; rnd3 = '0;
    m_cnt = 0; m_full = 0;
    #12;
    check_outputs();
    nrst = 1'b1;
    step();

    // Zero masks: share 0 carries the data, share 1 is all zero.
    load_table(1'b0);
    check_recomb("zero_rnd");
    chk("zero_rnd_share1", 384'(share({128'b0, sh_pt2}, 2, 1) | share({128'b0, sh_key2}, 2, 1)), 384'b0);
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;

    // Random masks, then hold with core_ready low while upstream keeps offering words.
    load_table(1'b1);
    check_recomb("rand_rnd");
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_data  = $urandom;
      rnd3     = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    core_ready = 1'b1;
    step();
    chk("after_xfer_in_ready", 384'(in_ready2), 384'(1));
    chk("after_xfer_sh_pt", {128'b0, sh_pt2}, 384'b0);
    core_ready = 1'b0;

    // Abort after five words; the word offered with clear must be dropped.
    for (int i = 0; i < 5; i++) load_word($urandom, {$urandom, $urandom});
    clear = 1'b1;
    load_word($urandom, {$urandom, $urandom});
    clear = 1'b0;
    chk("clear_busy", 384'(busy2), 384'(0));
    load_table(1'b1);
    check_recomb("after_clear");

    // Asynchronous reset while FULL drops the block immediately.
    #2 nrst = 1'b0;
    #1;
    m_cnt = 0;
    m_full = 0;
    check_outputs();
    #1 nrst = 1'b1;
    step();

    // Back-to-back blocks: one core_valid every 9 cycles.
    in_valid = 1'b1;
    core_ready = 1'b1;
    pulses = 0; first_pulse = -1; second_pulse = -1;
    for (int i = 0; i < 36; i++) begin
      in_data = $urandom;
      rnd3    = {$urandom, $urandom};
      step();
      if (core_valid2) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        else if (second_pulse < 0) second_pulse = i;
      end
    end
    chk("b2b_pulses", 384'(pulses), 384'(4));
    chk("b2b_period", 384'(second_pulse - first_pulse), 384'(9));
    chk("b2b_end_busy", 384'(busy2), 384'(0));
    in_valid = 1'b0;

    // Randomized traffic including clears.
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      core_ready = $urandom_range(0, 1);
      clear      = ($urandom_range(0, 31) == 0);
      in_data    = $urandom;
      rnd3       = {$urandom, $urandom};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
